// File: rtl/popcount_window_acc_if.sv
// Sample-in / window-result-out handshake bundle for popcount_window_acc.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface popcount_window_acc_if #(
    parameter int ACC_W = 10
);
    logic [5:0]       cnt_in;
    logic             cnt_valid;
    logic             cnt_ready;
    logic [ACC_W-1:0] sum_out;
    logic [5:0]       peak_out;
    logic             above_thresh;
    logic             sum_valid;
    logic             sum_ready;

    modport master (
        output cnt_in, cnt_valid, sum_ready,
        input  cnt_ready, sum_out, peak_out, above_thresh, sum_valid
    );

    modport slave (
        input  cnt_in, cnt_valid, sum_ready,
        output cnt_ready, sum_out, peak_out, above_thresh, sum_valid
    );
endinterface

// File: rtl/popcount_window_acc.sv
// Sums WIN_LEN popcount samples per window and tracks the window peak.
// Each window result is held in a one-deep valid/ready register with a threshold flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ACCUM   | sample slot free: next sample may always be accepted
// BLOCKED | next sample is the final one and the result slot is occupied;
//         | it is accepted only in a cycle where the consumer drains
module popcount_window_acc #(
    parameter int WIN_LEN = 16,
    parameter int ACC_W   = 10,
    parameter int THRESH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    popcount_window_acc_if.slave  io,
    output logic [7:0]            sample_idx,
    output logic                  err_illegal
);

    if (WIN_LEN < 2 || WIN_LEN > 256) begin : g_bad_win_len
        $error("popcount_window_acc: WIN_LEN must be within 2..256");
    end
    if ((64'd1 << ACC_W) <= 64'(32 * WIN_LEN)) begin : g_bad_acc_w
        $error("popcount_window_acc: ACC_W too narrow for 32*WIN_LEN");
    end

    localparam logic [7:0] LAST_IDX = 8'(WIN_LEN - 1);
    localparam logic [5:0] MAX_CNT  = 6'd32;

    typedef enum logic {
        ACCUM   = 1'b0,
        BLOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [5:0]       peak_q, peak_d;
    logic [7:0]       sample_idx_q, sample_idx_d;
    logic [ACC_W-1:0] sum_out_q, sum_out_d;
    logic [5:0]       peak_out_q, peak_out_d;
    logic             above_thresh_q, above_thresh_d;
    logic             sum_valid_q, sum_valid_d;
    logic             err_illegal_q, err_illegal_d;

    logic             cnt_ready;
    logic             accept;
    logic             is_last;
    logic             illegal;
    logic [5:0]       sample_sat;
    logic [ACC_W-1:0] win_sum;
    logic [5:0]       peak_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            acc_q          <= '0;
            peak_q         <= '0;
            sample_idx_q   <= '0;
            sum_out_q      <= '0;
            peak_out_q     <= '0;
            above_thresh_q <= 1'b0;
            sum_valid_q    <= 1'b0;
            err_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            peak_q         <= peak_d;
            sample_idx_q   <= sample_idx_d;
            sum_out_q      <= sum_out_d;
            peak_out_q     <= peak_out_d;
            above_thresh_q <= above_thresh_d;
            sum_valid_q    <= sum_valid_d;
            err_illegal_q  <= err_illegal_d;
        end
    end

    // Datapath terms shared by the final and non-final accept paths.
    always_comb begin
        illegal    = io.cnt_in > MAX_CNT;
        sample_sat = illegal ? MAX_CNT : io.cnt_in;
        win_sum    = acc_q + {{(ACC_W-6){1'b0}}, sample_sat};
        peak_new   = (sample_sat > peak_q) ? sample_sat : peak_q;
        is_last    = sample_idx_q == LAST_IDX;
    end

    // BLOCKED only stalls when the consumer is not draining this cycle.
    always_comb begin
        cnt_ready = 1'b0;
        if (!clear) begin
            cnt_ready = (state_q == ACCUM) || io.sum_ready;
        end
        accept = io.cnt_valid && cnt_ready;
    end

    always_comb begin
        acc_d          = acc_q;
        peak_d         = peak_q;
        sample_idx_d   = sample_idx_q;
        sum_out_d      = sum_out_q;
        peak_out_d     = peak_out_q;
        above_thresh_d = above_thresh_q;
        sum_valid_d    = sum_valid_q;
        err_illegal_d  = err_illegal_q;

        if (sum_valid_q && io.sum_ready) begin
            sum_valid_d = 1'b0;
        end

        if (clear) begin
            acc_d         = '0;
            peak_d        = '0;
            sample_idx_d  = '0;
            err_illegal_d = 1'b0;
        end else if (accept) begin
            if (illegal) begin
                err_illegal_d = 1'b1;
            end
            if (is_last) begin
                sum_out_d      = win_sum;
                peak_out_d     = peak_new;
                above_thresh_d = int'(win_sum) >= THRESH;
                sum_valid_d    = 1'b1;
                acc_d          = '0;
                peak_d         = '0;
                sample_idx_d   = '0;
            end else begin
                acc_d        = win_sum;
                peak_d       = peak_new;
                sample_idx_d = sample_idx_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = ACCUM;
        if (sample_idx_d == LAST_IDX && sum_valid_d) begin
            state_d = BLOCKED;
        end
    end

    assign io.cnt_ready    = cnt_ready;
    assign io.sum_out      = sum_out_q;
    assign io.peak_out     = peak_out_q;
    assign io.above_thresh = above_thresh_q;
    assign io.sum_valid    = sum_valid_q;
    assign sample_idx      = sample_idx_q;
    assign err_illegal     = err_illegal_q;

endmodule

// File: tb/tb_popcount_window_acc.sv
// Bench for popcount_window_acc: directed scenarios plus a randomized run,
// all compared against a queue-based window model.
module tb_popcount_window_acc;
    localparam int WIN_LEN = 16;
    localparam int ACC_W   = 10;
    localparam int THRESH  = 256;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] sample_idx;
    logic       err_illegal;

    popcount_window_acc_if #(.ACC_W(ACC_W)) io();

    popcount_window_acc #(
        .WIN_LEN (WIN_LEN),
        .ACC_W   (ACC_W),
        .THRESH  (THRESH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .io          (io),
        .sample_idx  (sample_idx),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: accepted (saturated) samples of the open window plus the pending result.
    int win_q[$];
    bit m_sv;
    int m_sum;
    int m_peak;
    bit m_th;
    bit m_err;

    function automatic bit m_rdy();
        if (clear) return 1'b0;
        return !(win_q.size() == WIN_LEN - 1 && m_sv && !io.sum_ready);
    endfunction

    task automatic model_reset();
        win_q.delete();
        m_sv = 0; m_sum = 0; m_peak = 0; m_th = 0; m_err = 0;
    endtask

    task automatic drive(input bit v, input int x, input bit r);
        io.cnt_valid = v;
        io.cnt_in    = 6'(x);
        io.sum_ready = r;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        bit         acc_now = m_rdy() && io.cnt_valid;
        bit         drain   = m_sv && io.sum_ready;
        bit         clr     = clear;
        logic [5:0] cin     = io.cnt_in;
        int         s, sum, pk;
        @(posedge clk);
        if (clr) begin
            win_q.delete();
            m_err = 0;
        end
        if (drain) m_sv = 0;
        if (acc_now) begin
            s = (cin > 6'd32) ? 32 : int'(cin);
            if (cin > 6'd32) m_err = 1;
            win_q.push_back(s);
            if (win_q.size() == WIN_LEN) begin
                sum = 0; pk = 0;
                foreach (win_q[i]) begin
                    sum += win_q[i];
                    if (win_q[i] > pk) pk = win_q[i];
                end
                m_sum = sum; m_peak = pk; m_th = (sum >= THRESH); m_sv = 1;
                win_q.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        drive(0, 0, 0);
        clear = 0;
        rst_n = 0;
        #12;
        checks++;
        if ({io.sum_valid, io.above_thresh, err_illegal} !== 3'b000 || io.sum_out !== '0 ||
            io.peak_out !== 6'd0 || sample_idx !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: sv=%b th=%b err=%b sum=%0d peak=%0d idx=%0d, want all 0",
                     io.sum_valid, io.above_thresh, err_illegal, io.sum_out, io.peak_out, sample_idx);
        end
        @(posedge clk);
        #1 rst_n = 1;
        #1;
        checks++;
        if (io.cnt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cnt_ready=%b want 1", io.cnt_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * WIN_LEN; i++) begin
            drive(1, 32, 1);
            checks++;
            if (io.cnt_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: cnt_ready=%b want 1", i, io.cnt_ready);
            end
            tick();
            checks++;
            if (io.sum_valid !== (i == WIN_LEN - 1 || i == 2 * WIN_LEN - 1)) begin
                errors++;
                $display("FAIL b2b_valid[%0d]: sum_valid=%b", i, io.sum_valid);
            end
            if (io.sum_valid === 1'b1) begin
                checks++;
                if (io.sum_out !== 10'd512 || io.peak_out !== 6'd32 || io.above_thresh !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: sum=%0d peak=%0d th=%b want 512 32 1",
                             i, io.sum_out, io.peak_out, io.above_thresh);
                end
            end
        end
    endtask

    task automatic test_mixed();
        for (int i = 0; i < WIN_LEN; i++) begin
            drive(1, i, 1);
            tick();
        end
        checks++;
        if (io.sum_valid !== 1'b1 || io.sum_out !== 10'd120 || io.peak_out !== 6'd15 ||
            io.above_thresh !== 1'b0) begin
            errors++;
            $display("FAIL mixed_result: sv=%b sum=%0d peak=%0d th=%b want 1 120 15 0",
                     io.sum_valid, io.sum_out, io.peak_out, io.above_thresh);
        end
    endtask

    task automatic test_backpressure();
        int first_sum;
        drive(0, 0, 1);
        clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < WIN_LEN; i++) begin
            drive(1, int'($urandom_range(0, 32)), 1);
            tick();
        end
        first_sum = m_sum;
        for (int i = 0; i < WIN_LEN - 1; i++) begin
            drive(1, int'($urandom_range(0, 32)), 0);
            checks++;
            if (io.cnt_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_nonfinal_ready[%0d]: cnt_ready=%b want 1", i, io.cnt_ready);
            end
            tick();
        end
        checks++;
        if (sample_idx !== 8'd15 || io.sum_valid !== 1'b1 || io.sum_out !== ACC_W'(first_sum)) begin
            errors++;
            $display("FAIL bp_hold: idx=%0d sv=%b sum=%0d want 15 1 %0d",
                     sample_idx, io.sum_valid, io.sum_out, first_sum);
        end
        drive(1, 9, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (io.cnt_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_final_stall[%0d]: cnt_ready=%b want 0", i, io.cnt_ready);
            end
            tick();
        end
        checks++;
        if (sample_idx !== 8'd15 || io.sum_out !== ACC_W'(first_sum)) begin
            errors++;
            $display("FAIL bp_stable: idx=%0d sum=%0d want 15 %0d", sample_idx, io.sum_out, first_sum);
        end
        io.sum_ready = 1;
        #1;
        checks++;
        if (io.cnt_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_ready: cnt_ready=%b want 1", io.cnt_ready);
        end
        tick();
        checks++;
        if (io.sum_valid !== 1'b1 || io.sum_out !== ACC_W'(m_sum) || sample_idx !== 8'd0) begin
            errors++;
            $display("FAIL bp_reload: sv=%b sum=%0d idx=%0d want 1 %0d 0",
                     io.sum_valid, io.sum_out, sample_idx, m_sum);
        end
        drive(0, 0, 1);
        tick();
        checks++;
        if (io.sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: sum_valid=%b want 0", io.sum_valid);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1, 10, 1);
            tick();
        end
        drive(1, 7, 1);
        clear = 1;
        #1;
        checks++;
        if (io.cnt_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: cnt_ready=%b want 0", io.cnt_ready);
        end
        tick();
        clear = 0;
        checks++;
        if (sample_idx !== 8'd0) begin
            errors++;
            $display("FAIL clear_idx: idx=%0d want 0", sample_idx);
        end
        for (int i = 0; i < WIN_LEN; i++) begin
            drive(1, 1, 1);
            tick();
        end
        checks++;
        if (io.sum_valid !== 1'b1 || io.sum_out !== 10'd16 || io.peak_out !== 6'd1) begin
            errors++;
            $display("FAIL clear_result: sv=%b sum=%0d peak=%0d want 1 16 1",
                     io.sum_valid, io.sum_out, io.peak_out);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < WIN_LEN; i++) begin
            drive(1, (i == 0) ? 40 : 0, 1);
            tick();
            checks++;
            if (err_illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_sticky[%0d]: err_illegal=%b want 1", i, err_illegal);
            end
        end
        checks++;
        if (io.sum_out !== 10'd32 || io.peak_out !== 6'd32 || io.above_thresh !== 1'b0) begin
            errors++;
            $display("FAIL illegal_result: sum=%0d peak=%0d th=%b want 32 32 0",
                     io.sum_out, io.peak_out, io.above_thresh);
        end
        drive(0, 0, 1);
        clear = 1;
        tick();
        clear = 0;
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: err_illegal=%b want 0", err_illegal);
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 9) < 8), int'($urandom_range(0, 40)), ($urandom_range(0, 2) != 0));
            clear = ($urandom_range(0, 49) == 0);
            #1;
            exp_rdy = m_rdy();
            checks++;
            if (io.cnt_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready[%0d]: cnt_ready=%b want %b", n, io.cnt_ready, exp_rdy);
            end
            tick();
            clear = 0;
            checks++;
            if (io.sum_valid !== m_sv || sample_idx !== 8'(win_q.size()) || err_illegal !== m_err) begin
                errors++;
                $display("FAIL rand_state[%0d]: sv=%b idx=%0d err=%b want %b %0d %b",
                         n, io.sum_valid, sample_idx, err_illegal, m_sv, win_q.size(), m_err);
            end
            if (m_sv) begin
                checks++;
                if (io.sum_out !== ACC_W'(m_sum) || io.peak_out !== 6'(m_peak) || io.above_thresh !== m_th) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: sum=%0d peak=%0d th=%b want %0d %0d %b",
                             n, io.sum_out, io.peak_out, io.above_thresh, m_sum, m_peak, m_th);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1);
        clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < WIN_LEN + 3; i++) begin
            drive(1, 20, 0);
            tick();
        end
        checks++;
        if (io.sum_valid !== 1'b1 || sample_idx !== 8'd3) begin
            errors++;
            $display("FAIL arst_setup: sv=%b idx=%0d want 1 3", io.sum_valid, sample_idx);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({io.sum_valid, io.above_thresh, err_illegal} !== 3'b000 || io.sum_out !== '0 ||
            io.peak_out !== 6'd0 || sample_idx !== 8'd0) begin
            errors++;
            $display("FAIL arst_outputs: sv=%b th=%b err=%b sum=%0d peak=%0d idx=%0d, want all 0",
                     io.sum_valid, io.above_thresh, err_illegal, io.sum_out, io.peak_out, sample_idx);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < WIN_LEN; i++) begin
            drive(1, 5, 1);
            tick();
        end
        checks++;
        if (io.sum_valid !== 1'b1 || io.sum_out !== 10'd80 || io.peak_out !== 6'd5) begin
            errors++;
            $display("FAIL arst_after: sv=%b sum=%0d peak=%0d want 1 80 5",
                     io.sum_valid, io.sum_out, io.peak_out);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mixed();
        test_backpressure();
        test_clear();
        test_illegal();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_window_acc.md
# popcount_window_acc

Sequential accumulator directly downstream of the 32-input population counter. Each cycle it accepts one 6-bit popcount (0..32) over a valid/ready handshake, sums WIN_LEN consecutive samples into a window total, and tracks the per-window peak sample. It presents the window result through a one-deep valid/ready output register with a threshold flag. Typical use is density/activity detection on 32-bit data words.

## Interface
- WIN_LEN, 16: samples per window; legal range 2..256.
- ACC_W, 10: accumulator/sum width; must satisfy 2^ACC_W > 32*WIN_LEN (elaboration error otherwise).
- THRESH, 256: window-sum threshold for above_thresh.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous window abort.
- cnt_in  input  6  popcount sample; legal 0..32.
- cnt_valid  input  1  cnt_in valid.
- cnt_ready  output  1  block accepts cnt_in this cycle.
- sum_out  output  ACC_W  completed window total.
- peak_out  output  6  max sample within the completed window.
- above_thresh  output  1  sum_out >= THRESH; qualified by sum_valid.
- sum_valid  output  1  result register holds an unconsumed window.
- sum_ready  input  1  consumer takes result.
- sample_idx  output  8  samples accepted in current window (0..WIN_LEN-1).
- err_illegal  output  1  sticky: an accepted cnt_in exceeded 32.

## Operation
- A sample is accepted when cnt_valid && cnt_ready at a rising edge.
- Accepted cnt_in > 32 is saturated to 32 before use, and err_illegal is set.
- Internal state is acc (ACC_W bits), peak (6 bits) and sample_idx. The FSM has two states:
  - ACCUM: normal accumulation.
  - BLOCKED: sample_idx == WIN_LEN-1, sum_valid=1 and sum_ready=0.
- cnt_ready = !clear && (sample_idx != WIN_LEN-1 || !sum_valid || sum_ready).
  - Non-final samples are always accepted while the output is pending.
  - The final sample waits only when the output slot is occupied and not draining.
- Non-final accept: acc += sample, peak = max(peak, sample), sample_idx += 1.
- Final accept (sample_idx == WIN_LEN-1):
  - sum_out <= acc + sample; peak_out <= max(peak, sample); above_thresh <= (acc + sample >= THRESH).
  - sum_valid <= 1; acc, peak, sample_idx <= 0.
  - The next window starts immediately, with no bubble.
- Output drain: sum_valid && sum_ready clears sum_valid.
  - If a final accept happens in the same cycle, the new result loads and sum_valid stays 1.
  - sum_out, peak_out and above_thresh hold their values while sum_valid=1 && !sum_ready.
- clear=1:
  - acc, peak, sample_idx <= 0; err_illegal <= 0; cnt_ready=0, so no sample is consumed.
  - The pending output register and sum_valid are untouched; clear && sum_ready still drains normally.
- The accumulator cannot overflow given the ACC_W rule; no wrap logic is required.

## Timing
- Reset (rst_n=0, asynchronous): sum_out=0, peak_out=0, above_thresh=0, sum_valid=0, sample_idx=0, err_illegal=0, acc=0, state ACCUM.
  - cnt_ready=1 in the first cycle after release, provided clear=0.
- Reset mid-window discards partial and pending results.
- Latency: a final sample accepted at edge k gives sum_valid=1 and valid sum_out/peak_out/above_thresh immediately after edge k (1 cycle).
- Throughput is one sample per cycle, including across window boundaries, when the consumer holds sum_ready=1.
- cnt_ready is combinational from sum_valid, sum_ready, clear and registered sample_idx. It has no combinational path from cnt_valid.
- err_illegal rises the cycle after the offending accept.

## Test plan
- Back-to-back windows:
  - Stimulus: WIN_LEN=16, sum_ready=1, 32 samples of cnt_in=32 with no gaps.
  - Required: sum_valid pulses after accepts 16 and 32; sum_out=512, peak_out=32, above_thresh=1 both times; cnt_ready never drops.
- Mixed values:
  - Stimulus: samples 0,1,2,...,15.
  - Required: sum_out=120, peak_out=15, above_thresh=0 (THRESH=256).
- Backpressure:
  - Stimulus: sum_ready=0 after the first window completes, then 15 more samples.
  - Required: all 15 accepted (sample_idx=15); cnt_ready=0 on the 16th; the first result stays stable.
  - Then: assert sum_ready for 1 cycle; the 16th sample is accepted in that cycle and sum_valid stays 1 with the new sum.
- Clear mid-window:
  - Stimulus: 5 samples of 10, then clear with cnt_valid=1 and cnt_in=7, then 16 samples of 1.
  - Required: cnt_ready=0 during clear; the next result is sum_out=16, peak_out=1.
- Illegal input:
  - Stimulus: one sample cnt_in=40, with the rest 0.
  - Required: treated as 32; sum_out=32; err_illegal=1 until clear or reset.
- Async reset:
  - Stimulus: assert rst_n=0 mid-window with sum_valid=1 and no clock edge.
  - Required: all outputs 0 immediately.
